cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Instruction-cycle sequencer for the 8-bit CPU. It steps the core through FETCH, DECODE, EXEC and WB by driving one-hot stage enables, and supports free-run, single-step (debounced pushbutton) and halt. It sits between the power-on/button reset sequencer and the CPU datapath: it holds the core idle while the sequencer asserts `cpu_rst`, then schedules every datapath stage.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a `step_btn` level change; legal range ≥2.
- `clk_sys`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset; highest priority.
- `cpu_rst`  in  1  active-high hold from the reset sequencer (its `pc_rst`); synchronous effect.
- `run_sw`  in  1  1 = free run, 0 = single-step.
- `step_btn`  in  1  raw, asynchronous, bouncy pushbutton; active high.
- `halt_req`  in  1  HLT decoded by the datapath; sampled only in EXEC.
- `mem_busy`  in  1  memory wait; stalls FETCH and WB only.
- `fetch_en`, `decode_en`, `exec_en`, `wb_en`  out  1 each  stage enables; at most one high.
- `halted`  out  1  high in HALT.
- `instr_count`  out  8  retired-instruction counter.
- `state`  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.

## Operation
- Reset (`sys_rst`=1): state IDLE; all enables 0; `halted`=0; `instr_count`=0; halt latch 0; sync flops, debounced level and debounce counter 0.
- `cpu_rst`=1, `sys_rst`=0: same clearing as `sys_rst`, except the button synchronizer and debouncer keep running. This applies from any state, including mid-instruction and HALT.
- Enables are Moore-decoded from `state`: `fetch_en` = (state==FETCH), and likewise for the other stages. In IDLE and HALT every enable is 0.
- IDLE:
  - `run_sw`=1 → FETCH.
  - `run_sw`=0 and `step_pulse`=1 → FETCH.
  - Otherwise stay in IDLE.
- FETCH → DECODE when `mem_busy`=0; otherwise hold with `fetch_en` still high.
- DECODE → EXEC unconditionally.
- EXEC → WB unconditionally. Halt latch ← `halt_req`.
- WB, when `mem_busy`=0:
  - `instr_count` += 1, mod 256 (255 → 0).
  - Next state: HALT if the halt latch is set, else FETCH if `run_sw`=1, else IDLE.
- WB with `mem_busy`=1: hold with `wb_en` high; no count.
- HALT: stay until `sys_rst` or `cpu_rst`. Ignores `run_sw`, step and `mem_busy`.
- `run_sw` is sampled only in IDLE and on WB completion. Clearing it mid-instruction finishes the current instruction, then goes to IDLE.
- Debounce:
  - `step_btn` → 2-flop synchronizer → `sync`.
  - Counter clears when `sync`==`deb` and increments when they differ.
  - When the counter equals `DEBOUNCE_CYCLES-1` and they still differ, `deb` ← `sync` and the counter clears.
  - `step_pulse` = `deb & ~deb_q`, a one-cycle pulse on each accepted rising level.
- `step_pulse` is consumed only in IDLE with `run_sw`=0. Pulses in any other state or mode are dropped, not queued.

## Timing
- Unstalled instruction: 4 cycles (FETCH, DECODE, EXEC, WB). Run mode gives back-to-back instructions with no IDLE gap.
- Each `mem_busy`=1 cycle in FETCH or WB adds exactly 1 cycle.
- `instr_count` updates on the edge leaving WB, simultaneously with entry to the next state.
- Step latency: `step_btn` first sampled high at edge 0 and held stable.
  - `sync` = 1 after edge 1.
  - `deb` = 1 after edge 1+`DEBOUNCE_CYCLES`.
  - FETCH entered at edge 2+`DEBOUNCE_CYCLES` (edge 6 for the default).
- Bounces shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no pulse. Release is debounced identically.
- `halt_req` outside EXEC has no effect. `halt_req` in EXEC reaches HALT only after WB completes, so the HLT instruction is counted.
- Simultaneous events: `sys_rst` beats `cpu_rst`, which beats all state transitions. `cpu_rst` asserted in the same cycle as WB completion means no count increment and next state IDLE.

## Test plan
- Reset/run: `sys_rst` 2 cycles, `cpu_rst`=0, `run_sw`=1, `mem_busy`=0 → `state` sequence 1,2,3,4,1,… with exactly one enable high. After 10 instructions (40 cycles), `instr_count`=10.
- Stall: `mem_busy`=1 for 3 cycles in FETCH and 2 in WB → that instruction takes 9 cycles; `fetch_en` held 4 cycles, `wb_en` held 3; count +1 once.
- Step/debounce (D=4): `run_sw`=0; pulse `step_btn` with bounces 1,0,1,0 then stable 1 for 10 cycles → exactly one instruction; FETCH at edge 6 after the first stable sample; returns to IDLE with count +1. A second press while in DECODE is ignored.
- Halt: run mode, `halt_req`=1 during the 3rd instruction's EXEC → WB completes, `instr_count`=3, `halted`=1, enables 0. Stays halted 50 cycles despite `run_sw` toggles and step presses. Pulsing `cpu_rst` → IDLE, `halted`=0, count 0.
- Wrap and mid-op reset: preload 255 instructions, next WB → `instr_count`=0. Assert `cpu_rst` in EXEC → next cycle IDLE, enables 0, no count. Assert `sys_rst` together with `cpu_rst` → full reset values.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Instruction-cycle sequencer: steps the core through FETCH/DECODE/EXEC/WB,
// with free-run, debounced single-step and halt.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_sys,
  input  logic       sys_rst,
  input  logic       cpu_rst,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic       halt_req,
  input  logic       mem_busy,
  output logic       fetch_en,
  output logic       decode_en,
  output logic       exec_en,
  output logic       wb_en,
  output logic       halted,
  output logic [7:0] instr_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  state_t        state_q;
  state_t        state_n;
  logic          count_inc;
  logic          halt_latch;
  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] deb_cnt;
  logic          step_pulse;

  // The debouncer only obeys sys_rst so a button held across cpu_rst is not re-accepted.
  always_ff @(posedge clk_sys) begin
    if (sys_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_MAX) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign step_pulse = deb & ~deb_q;

  always_comb begin
    state_n   = state_q;
    count_inc = 1'b0;
    case (state_q)
      S_IDLE:   if (run_sw || step_pulse) state_n = S_FETCH;
      S_FETCH:  if (!mem_busy) state_n = S_DECODE;
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = S_WB;
      S_WB: begin
        if (!mem_busy) begin
          count_inc = 1'b1;
          if (halt_latch)  state_n = S_HALT;
          else if (run_sw) state_n = S_FETCH;
          else             state_n = S_IDLE;
        end
      end
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase
  end

  // Enables and halted are decoded from the next state so they are registered with it.
  always_ff @(posedge clk_sys) begin
    if (sys_rst || cpu_rst) begin
      state_q     <= S_IDLE;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      wb_en       <= 1'b0;
      halted      <= 1'b0;
      instr_count <= 8'd0;
      halt_latch  <= 1'b0;
    end else begin
      state_q   <= state_n;
      fetch_en  <= (state_n == S_FETCH);
      decode_en <= (state_n == S_DECODE);
      exec_en   <= (state_n == S_EXEC);
      wb_en     <= (state_n == S_WB);
      halted    <= (state_n == S_HALT);
      if (state_q == S_EXEC) halt_latch <= halt_req;
      if (count_inc) instr_count <= instr_count + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: run, stalls, debounced step, halt, wrap and resets.
module tb_cpu_run_ctrl;

  logic       clk_sys;
  logic       sys_rst;
  logic       cpu_rst;
  logic       run_sw;
  logic       step_btn;
  logic       halt_req;
  logic       mem_busy;
  logic       fetch_en;
  logic       decode_en;
  logic       exec_en;
  logic       wb_en;
  logic       halted;
  logic [7:0] instr_count;
  logic [2:0] state;

  int tests_run = 0;
  int fails     = 0;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_sys     (clk_sys),
    .sys_rst     (sys_rst),
    .cpu_rst     (cpu_rst),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .mem_busy    (mem_busy),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .exec_en     (exec_en),
    .wb_en       (wb_en),
    .halted      (halted),
    .instr_count (instr_count),
    .state       (state)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_en(input int s);
    case (s)
      1:       return 4'b1000;
      2:       return 4'b0100;
      3:       return 4'b0010;
      4:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check_st(input string tag, input int s);
    check({tag, "_state"}, {29'd0, state}, s);
    check({tag, "_en"}, {28'd0, fetch_en, decode_en, exec_en, wb_en}, {28'd0, exp_en(s)});
    check({tag, "_halted"}, {31'd0, halted}, (s == 5) ? 1 : 0);
  endtask

  task automatic check_cnt(input string tag, input int n);
    check(tag, {24'd0, instr_count}, n);
  endtask

  initial begin
    sys_rst  = 1'b1;
    cpu_rst  = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    mem_busy = 1'b0;

    // Reset values
    tick();
    tick();
    check_st("reset", 0);
    check_cnt("reset_cnt", 0);

    // Free run: 10 back-to-back instructions
    sys_rst = 1'b0;
    run_sw  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_st("run_seq", (i % 4) + 1);
    end
    check_cnt("run_cnt_pre", 9);
    tick();
    check_st("run_after10", 1);
    check_cnt("run_cnt10", 10);

    // Stall: 3 busy cycles in FETCH, 2 in WB
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_st("stall_fetch", 1);
    end
    mem_busy = 1'b0;
    tick(); check_st("stall_dec", 2);
    tick(); check_st("stall_exec", 3);
    tick(); check_st("stall_wb0", 4);
    mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_st("stall_wb", 4);
      check_cnt("stall_wb_cnt", 10);
    end
    mem_busy = 1'b0;
    tick();
    check_st("stall_done", 1);
    check_cnt("stall_cnt", 11);

    // Clearing run_sw mid-instruction finishes it, then idles
    run_sw = 1'b0;
    tick(); check_st("stop_dec", 2);
    tick(); check_st("stop_exec", 3);
    tick(); check_st("stop_wb", 4);
    tick(); check_st("stop_idle", 0);
    check_cnt("stop_cnt", 12);

    // Bouncy press: 1,0,1,0 then stable high
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    check_st("bounce_idle", 0);
    step_btn = 1'b1;
    tick();  // edge 0: first stable sample
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_st("step_wait", 0);
    end
    tick();  // edge 6
    check_st("step_fetch", 1);

    // Hold FETCH, release and re-press so the second pulse lands in DECODE
    mem_busy = 1'b1;
    step_btn = 1'b0;
    for (int e = 7; e <= 12; e++) begin
      tick();
      check_st("step_hold", 1);
    end
    step_btn = 1'b1;
    for (int e = 13; e <= 17; e++) begin
      tick();
      check_st("step_hold2", 1);
    end
    mem_busy = 1'b0;
    tick(); check_st("step_dec", 2);
    tick(); check_st("step_exec", 3);
    tick(); check_st("step_wb", 4);
    tick(); check_st("step_idle", 0);
    check_cnt("step_cnt", 13);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_st("step_dropped", 0);
    end
    check_cnt("step_cnt_hold", 13);
    step_btn = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_st("step_release", 0);

    // Halt on the 3rd instruction
    cpu_rst = 1'b1;
    tick();
    check_st("halt_pre_rst", 0);
    check_cnt("halt_pre_cnt", 0);
    cpu_rst = 1'b0;
    run_sw  = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      halt_req = (e == 6 || e == 11);  // DECODE of instr 2 (ignored), EXEC of instr 3
      check_st("halt_run", ((e - 1) % 4) + 1);
    end
    halt_req = 1'b0;
    tick();
    check_st("halt_entered", 5);
    check_cnt("halt_cnt", 3);
    for (int i = 0; i < 50; i++) begin
      run_sw   = i[0];
      step_btn = i[3];
      mem_busy = i[1];
      tick();
      check_st("halt_stay", 5);
    end
    check_cnt("halt_cnt_stay", 3);
    cpu_rst  = 1'b1;
    run_sw   = 1'b1;
    step_btn = 1'b0;
    mem_busy = 1'b0;
    tick();
    check_st("halt_cpu_rst", 0);
    check_cnt("halt_rst_cnt", 0);
    cpu_rst = 1'b0;

    // Preload 255 instructions, then wrap
    for (int i = 0; i < 4 * 255 + 1; i++) tick();
    check_st("wrap_pre", 1);
    check_cnt("wrap_pre_cnt", 255);
    tick(); tick(); tick();
    check_st("wrap_wb", 4);
    check_cnt("wrap_wb_cnt", 255);
    tick();
    check_st("wrap_fetch", 1);
    check_cnt("wrap_cnt", 0);

    // cpu_rst in EXEC
    tick(); tick(); tick(); tick();
    check_cnt("midrst_pre_cnt", 1);
    tick(); tick();
    check_st("midrst_exec", 3);
    cpu_rst = 1'b1;
    tick();
    check_st("midrst_idle", 0);
    check_cnt("midrst_cnt", 0);

    // cpu_rst coincident with WB completion: no count, IDLE
    cpu_rst = 1'b0;
    tick(); tick(); tick(); tick();
    check_st("wbrst_wb", 4);
    cpu_rst = 1'b1;
    tick();
    check_st("wbrst_idle", 0);
    check_cnt("wbrst_cnt", 0);

    // sys_rst together with cpu_rst
    cpu_rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_st("both_pre", 2);
    check_cnt("both_pre_cnt", 1);
    sys_rst = 1'b1;
    cpu_rst = 1'b1;
    tick();
    check_st("both_rst", 0);
    check_cnt("both_cnt", 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
